// File: rtl/vram_console_pkg.sv
// Shared types and constants for the VRAM text console.
package vram_console_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CUR_NONE = 3'd0,
    CUR_STEP = 3'd1,
    CUR_CR   = 3'd2,
    CUR_LF   = 3'd3,
    CUR_BS   = 3'd4,
    CUR_HOME = 3'd5
  } cur_op_t;

  localparam int COLS_DEF   = 60;
  localparam int ROWS_DEF   = 17;
  localparam int VRAM_DEPTH = 1024;
  localparam int VRAM_AW    = 10;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_SPACE = 8'h20;

  function automatic logic is_printable(input logic [7:0] c);
    return ((c >= 8'h20) && (c <= 8'h7E)) || (c >= 8'h80);
  endfunction

endpackage

// File: rtl/vram_cursor.sv
// Text cursor: column/row registers with wrap rules and linear VRAM address.
module vram_cursor
  import vram_console_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic                 MEMORY_CLK,
  input  logic                 rst_n,
  input  logic [2:0]           op,
  output logic [VRAM_AW-1:0]   addr
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [RW-1:0] row_adv;
  cur_op_t       op_e;

  assign op_e    = cur_op_t'(op);
  // No scrolling: the bottom row wraps back to the top.
  assign row_adv = (row == ROW_LAST) ? '0 : row + 1'b1;
  assign addr    = VRAM_AW'(row) * VRAM_AW'(COLS) + VRAM_AW'(col);

  always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else begin
      case (op_e)
        CUR_STEP: begin
          if (col == COL_LAST) begin
            col <= '0;
            row <= row_adv;
          end else begin
            col <= col + 1'b1;
          end
        end
        CUR_CR:   col <= '0;
        CUR_LF:   row <= row_adv;
        CUR_BS:   if (col != '0) col <= col - 1'b1;
        CUR_HOME: begin
          col <= '0;
          row <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vram_console.sv
// Character-stream to VRAM text console with boot fill and form-feed clear.
// VRAM_CONSOLE_BOOTFILL_EN: boot fill writes address[6:0] instead of spaces.
//
// state    | meaning
// ST_INIT  | boot fill of all VRAM addresses, then home cursor
// ST_IDLE  | waiting for a character (in_ready high)
// ST_WRITE | one-cycle slot presenting the accepted character's write
// ST_CLEAR | form-feed fill with spaces, then home cursor
module vram_console
  import vram_console_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic         MEMORY_CLK,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic [9:0]   v_ada,
  output logic [7:0]   v_din,
  output logic         v_cea,
  output logic         busy
);

  state_t              state;
  logic                ff_pend;
  cur_op_t             cur_op;
  logic [VRAM_AW-1:0]  cur_addr;
  logic [VRAM_AW-1:0]  fill_next;
  logic                fill_last;
  logic [7:0]          init_data;

  vram_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .MEMORY_CLK (MEMORY_CLK),
    .rst_n      (rst_n),
    .op         (cur_op),
    .addr       (cur_addr)
  );

  // The fill address lives in v_ada itself; v_cea low means nothing written yet.
  assign fill_next = v_cea ? v_ada + 1'b1 : '0;
  assign fill_last = v_cea && (v_ada == VRAM_AW'(VRAM_DEPTH - 1));

`ifdef VRAM_CONSOLE_BOOTFILL_EN
  assign init_data = {1'b0, fill_next[6:0]};
`else
  assign init_data = CH_SPACE;
`endif

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  always_comb begin
    cur_op = CUR_NONE;
    if (state == ST_IDLE && in_valid) begin
      if (is_printable(in_data)) begin
        cur_op = CUR_STEP;
      end else begin
        case (in_data)
          CH_CR:   cur_op = CUR_CR;
          CH_LF:   cur_op = CUR_LF;
          CH_BS:   cur_op = CUR_BS;
          default: cur_op = CUR_NONE;
        endcase
      end
    end else if ((state == ST_INIT || state == ST_CLEAR) && fill_last) begin
      cur_op = CUR_HOME;
    end
  end

  always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      v_ada   <= '0;
      v_din   <= CH_SPACE;
      v_cea   <= 1'b0;
      ff_pend <= 1'b0;
    end else begin
      case (state)
        ST_INIT, ST_CLEAR: begin
          if (fill_last) begin
            state <= ST_IDLE;
            v_cea <= 1'b0;
          end else begin
            v_cea <= 1'b1;
            v_ada <= fill_next;
            v_din <= (state == ST_INIT) ? init_data : CH_SPACE;
          end
        end
        ST_IDLE: begin
          if (in_valid) begin
            state   <= ST_WRITE;
            ff_pend <= (in_data == CH_FF);
            v_cea   <= is_printable(in_data);
            v_ada   <= cur_addr;
            v_din   <= in_data;
          end
        end
        ST_WRITE: begin
          if (ff_pend) begin
            // Address 0 goes out on the way into CLEAR so the clear costs exactly 1024 cycles.
            state   <= ST_CLEAR;
            ff_pend <= 1'b0;
            v_cea   <= 1'b1;
            v_ada   <= '0;
            v_din   <= CH_SPACE;
          end else begin
            state <= ST_IDLE;
            v_cea <= 1'b0;
          end
        end
        default: begin
          state <= ST_INIT;
          v_cea <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/vram_console.md
VRAM_CONSOLE -- requirements
Module: vram_console

Interface
REQ-001 SHALL have parameter COLS, default 60, meaning text columns per row (480 px / 8 px glyph).
REQ-002 SHALL have parameter ROWS, default 17, meaning text rows (272 px / 16 px glyph); COLS*ROWS SHALL be <= 1024.
REQ-003 SHALL have port MEMORY_CLK, input, 1 bit: clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: character available.
REQ-006 SHALL have port in_data, input, 8 bits: character code.
REQ-007 SHALL have port in_ready, output, 1 bit: console accepts a character.
REQ-008 SHALL have port v_ada, output, 10 bits: VRAM write address.
REQ-009 SHALL have port v_din, output, 8 bits: VRAM write data.
REQ-010 SHALL have port v_cea, output, 1 bit: VRAM write enable.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 SHALL implement the states INIT, IDLE, WRITE and CLEAR.
REQ-013 INIT and CLEAR SHALL write addresses 0..1023 in order, one per cycle with v_cea held high, then go to IDLE with the cursor at (row 0, col 0).
REQ-014 in_ready SHALL be high only in IDLE; a transfer SHALL occur when in_valid && in_ready are both high at a rising edge.
REQ-015 On a transfer the FSM SHALL go to WRITE for exactly one cycle, then return to IDLE, giving a maximum rate of one character per 2 cycles.
REQ-016 Printable (0x20..0x7E, 0x80..0xFF): in WRITE, v_cea=1, v_ada=row*COLS+col, v_din=in_data; col increments after the write.
REQ-017 Column wrap: when col==COLS-1, after the write col SHALL become 0 and row SHALL advance.
REQ-018 Row wrap: when row==ROWS-1 and the row advances, row SHALL become 0 (no scrolling).
REQ-019 0x0D (CR): col SHALL become 0; v_cea=0 in WRITE.
REQ-020 0x0A (LF): row SHALL advance with wrap; col unchanged; no write.
REQ-021 0x08 (BS): col SHALL decrement if col>0, else be unchanged; no write.
REQ-022 0x0C (FF): the FSM SHALL go from WRITE to CLEAR, filling with 0x20, then home the cursor.
REQ-023 All other control codes (0x00..0x1F, 0x7F) SHALL be consumed with no write and no cursor change.
REQ-024 The address SHALL be computed as row*COLS+col in 10 bits without overflow (maximum 1019 at the defaults); a shift/subtract form is acceptable.
REQ-025 v_cea SHALL be 0 in IDLE, and in_valid SHALL be ignored in every state other than IDLE.

Reset
REQ-026 On rst_n low, at any time including mid-write or mid-clear, the block SHALL asynchronously enter INIT with v_ada=0, v_cea=0, v_din=0x20, in_ready=0, busy=1 and the cursor at (0,0).
REQ-027 After release, INIT SHALL restart from address 0 on the first MEMORY_CLK edge.

Configuration
REQ-028 Macro VRAM_CONSOLE_BOOTFILL_EN SHALL select the INIT fill data.
- Defined: INIT writes data = address[6:0] (test pattern 0x00..0x7F repeating).
- Undefined: INIT writes 0x20.
- CLEAR always writes 0x20.

Structure
REQ-029 Package vram_console_pkg SHALL hold:
- the state enum;
- default COLS/ROWS;
- VRAM_DEPTH=1024;
- constants CH_CR, CH_LF, CH_BS, CH_FF, CH_SPACE.
REQ-030 Cursor tracking (col/row registers, wrap, address arithmetic) SHALL live in one sub-module, vram_cursor.

Verification
REQ-031 Reset release -> 1024 consecutive v_cea pulses at addresses 0..1023 with data 0x20 (0x00..0x7F with the macro), then in_ready=1 and busy=0.
REQ-032 Send 'A' (0x41) -> one cycle later v_cea=1, v_ada=0, v_din=0x41; the next 'B' is written at v_ada=1.
REQ-033 Send 60 printable characters, then 'X' -> 'X' is written at v_ada=60; send CR, LF, 'Y' -> 'Y' is written at v_ada=120.
REQ-034 With the cursor at row 16, col 59, send 'Z' -> written at 1019; the next char is written at 0.
REQ-035 Send 0x0C -> busy=1 for 1025 cycles (1 WRITE + 1024 CLEAR), all data 0x20; the next 'Q' is written at 0.
REQ-036 Assert rst_n low mid-CLEAR at address 500 -> v_cea=0 immediately; after release INIT restarts at address 0.
